// File: rtl/nx_loader_pkg.sv
// Shared encodings for the nx_riscv boot loader: targets, FSM states,
// command-word field positions and address stepping constants.
package nx_loader_pkg;

  typedef enum logic [1:0] {
    TGT_INST = 2'b00,
    TGT_DATA = 2'b01,
    TGT_REG  = 2'b10,
    TGT_GO   = 2'b11
  } target_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam int CMD_TGT_MSB   = 31;
  localparam int CMD_TGT_LSB   = 30;
  localparam int CMD_CNT_LSB   = 0;
  localparam int REGFILE_DEPTH = 32;
  localparam int RAM_ADDR_STEP = 4;
  localparam int REG_ADDR_STEP = 1;

  // Bits between the count field and the target field must be zero.
  function automatic logic cmd_reserved_clear(input logic [31:0] cmd, input int cnt_w);
    logic [31:0] reserved_mask;
    reserved_mask = 32'h3FFF_FFFF & ~((32'h1 << cnt_w) - 32'h1);
    return (cmd & reserved_mask) == 32'h0;
  endfunction

  function automatic logic is_ram_target(input target_t tgt);
    return (tgt == TGT_INST) || (tgt == TGT_DATA);
  endfunction

endpackage

// File: rtl/nx_loader_stall_timer.sv
// Stall watchdog for the boot loader: counts idle cycles inside a packet and
// flags expiry at LIMIT. LIMIT == 0 never expires.
module nx_loader_stall_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  logic [W-1:0] count_reg;
  logic         at_limit;

  assign at_limit = (count_reg == LIMIT_W);
  assign expire   = (LIMIT != 0) && at_limit;

  // Saturates at the limit so a disabled timer (LIMIT == 0) simply holds 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !at_limit) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/nx_boot_loader.sv
// Boot loader for nx_riscv: streams cmd/addr/payload words into the core's
// init ports and holds the core in reset until GO. Optional trailing checksum
// word enabled with NX_LOADER_CHECKSUM_EN.
module nx_boot_loader
  import nx_loader_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  output logic        inst_ram_wen,
  output logic [31:0] inst_ram_waddr,
  output logic [31:0] inst_ram_wdata,
  output logic        data_ram_wen_initial,
  output logic [31:0] data_ram_waddr_initial,
  output logic [31:0] data_ram_wdata_initial,
  output logic        regfile_wen_initial,
  output logic [4:0]  regfile_waddr_initial,
  output logic [31:0] regfile_wdata_initial,
  output logic        core_rst_n,
  output logic        ld_busy,
  output logic        ld_done,
  output logic        ld_err
);

  state_t           state_reg, state_next;
  target_t          tgt_reg, tgt_next;
  logic [CNT_W-1:0] remain_reg, remain_next;
  logic [31:0]      addr_reg, addr_next;
  logic             inst_wen_reg, inst_wen_next;
  logic             data_wen_reg, data_wen_next;
  logic             reg_wen_reg, reg_wen_next;
  logic [31:0]      wr_addr_reg, wr_addr_next;
  logic [31:0]      wr_data_reg, wr_data_next;

  logic             transfer;
  logic             stall_expire;
  target_t          cmd_tgt;
  logic [33:0]      reg_end;

  assign transfer = ld_valid && ld_ready;
  assign cmd_tgt  = target_t'(ld_data[CMD_TGT_MSB:CMD_TGT_LSB]);
  assign reg_end  = {2'b00, ld_data} + 34'(remain_reg);

  assign ld_ready   = (state_reg == ST_IDLE) || (state_reg == ST_ADDR) ||
                      (state_reg == ST_DATA) || (state_reg == ST_CSUM);
  assign ld_busy    = (state_reg == ST_ADDR) || (state_reg == ST_DATA) ||
                      (state_reg == ST_CSUM);
  assign ld_done    = (state_reg == ST_RUN);
  assign ld_err     = (state_reg == ST_ERR);
  assign core_rst_n = (state_reg == ST_RUN);

  // The three init ports share one registered address/data pair; only the
  // selected strobe qualifies it.
  assign inst_ram_wen           = inst_wen_reg;
  assign inst_ram_waddr         = wr_addr_reg;
  assign inst_ram_wdata         = wr_data_reg;
  assign data_ram_wen_initial   = data_wen_reg;
  assign data_ram_waddr_initial = wr_addr_reg;
  assign data_ram_wdata_initial = wr_data_reg;
  assign regfile_wen_initial    = reg_wen_reg;
  assign regfile_waddr_initial  = wr_addr_reg[4:0];
  assign regfile_wdata_initial  = wr_data_reg;

  nx_loader_stall_timer #(
    .LIMIT (STALL_TIMEOUT)
  ) u_stall_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (ld_busy && !transfer),
    .clear  (!ld_busy || transfer),
    .expire (stall_expire)
  );

`ifdef NX_LOADER_CHECKSUM_EN
  logic [31:0] csum_reg, csum_next;

  always_comb begin
    csum_next = csum_reg;
    if (transfer) begin
      case (state_reg)
        ST_IDLE:          csum_next = ld_data;
        ST_ADDR, ST_DATA: csum_next = csum_reg + ld_data;
        default:          csum_next = csum_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_reg <= '0;
    end else begin
      csum_reg <= csum_next;
    end
  end
`endif

  always_comb begin
    state_next    = state_reg;
    tgt_next      = tgt_reg;
    remain_next   = remain_reg;
    addr_next     = addr_reg;
    inst_wen_next = 1'b0;
    data_wen_next = 1'b0;
    reg_wen_next  = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;

    case (state_reg)
      ST_IDLE: begin
        if (transfer) begin
          if (!cmd_reserved_clear(ld_data, CNT_W)) begin
            state_next = ST_ERR;
          end else if (cmd_tgt == TGT_GO) begin
            state_next = ST_RUN;
          end else begin
            tgt_next    = cmd_tgt;
            remain_next = ld_data[CMD_CNT_LSB +: CNT_W];
            state_next  = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        if (stall_expire) begin
          state_next = ST_ERR;
        end else if (transfer) begin
          addr_next = ld_data;
          if (is_ram_target(tgt_reg) && (ld_data[1:0] != 2'b00)) begin
            state_next = ST_ERR;
          end else if ((tgt_reg == TGT_REG) && (reg_end > 34'(REGFILE_DEPTH))) begin
            state_next = ST_ERR;
          end else if (remain_reg == '0) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (stall_expire) begin
          state_next = ST_ERR;
        end else if (transfer) begin
          inst_wen_next = (tgt_reg == TGT_INST);
          data_wen_next = (tgt_reg == TGT_DATA);
          reg_wen_next  = (tgt_reg == TGT_REG);
          wr_addr_next  = addr_reg;
          wr_data_next  = ld_data;
          addr_next     = addr_reg + (is_ram_target(tgt_reg) ? 32'(RAM_ADDR_STEP)
                                                              : 32'(REG_ADDR_STEP));
          remain_next   = remain_reg - 1'b1;
          if (remain_reg == CNT_W'(1)) begin
`ifdef NX_LOADER_CHECKSUM_EN
            state_next = ST_CSUM;
`else
            state_next = ST_IDLE;
`endif
          end
        end
      end

`ifdef NX_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (stall_expire) begin
          state_next = ST_ERR;
        end else if (transfer) begin
          state_next = (ld_data == csum_reg) ? ST_IDLE : ST_ERR;
        end
      end
`endif

      ST_RUN:  state_next = ST_RUN;
      ST_ERR:  state_next = ST_ERR;
      default: state_next = ST_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      tgt_reg      <= TGT_INST;
      remain_reg   <= '0;
      addr_reg     <= '0;
      inst_wen_reg <= 1'b0;
      data_wen_reg <= 1'b0;
      reg_wen_reg  <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      tgt_reg      <= tgt_next;
      remain_reg   <= remain_next;
      addr_reg     <= addr_next;
      inst_wen_reg <= inst_wen_next;
      data_wen_reg <= data_wen_next;
      reg_wen_reg  <= reg_wen_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
    end
  end

endmodule

// File: tb/tb_nx_boot_loader.sv
// Scoreboard bench for nx_boot_loader: expected init writes are queued as
// words are accepted and matched against the strobes one cycle later.
module tb_nx_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_data = '0;
  logic        inst_ram_wen;
  logic [31:0] inst_ram_waddr;
  logic [31:0] inst_ram_wdata;
  logic        data_ram_wen_initial;
  logic [31:0] data_ram_waddr_initial;
  logic [31:0] data_ram_wdata_initial;
  logic        regfile_wen_initial;
  logic [4:0]  regfile_waddr_initial;
  logic [31:0] regfile_wdata_initial;
  logic        core_rst_n;
  logic        ld_busy;
  logic        ld_done;
  logic        ld_err;

  nx_boot_loader #(
    .STALL_TIMEOUT (8),
    .CNT_W         (16)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .ld_valid               (ld_valid),
    .ld_ready               (ld_ready),
    .ld_data                (ld_data),
    .inst_ram_wen           (inst_ram_wen),
    .inst_ram_waddr         (inst_ram_waddr),
    .inst_ram_wdata         (inst_ram_wdata),
    .data_ram_wen_initial   (data_ram_wen_initial),
    .data_ram_waddr_initial (data_ram_waddr_initial),
    .data_ram_wdata_initial (data_ram_wdata_initial),
    .regfile_wen_initial    (regfile_wen_initial),
    .regfile_waddr_initial  (regfile_waddr_initial),
    .regfile_wdata_initial  (regfile_wdata_initial),
    .core_rst_n             (core_rst_n),
    .ld_busy                (ld_busy),
    .ld_done                (ld_done),
    .ld_err                 (ld_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tgt;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: one strobe per cycle, matched in order against the queue.
  always @(negedge clk) begin : mon
    int          nwen;
    int          gt;
    logic [31:0] ga;
    logic [31:0] gd;
    exp_t        e;
    cyc = cyc + 1;
    nwen = int'(inst_ram_wen) + int'(data_ram_wen_initial) + int'(regfile_wen_initial);
    if (nwen != 0) begin
      check_eq("wen_onehot", nwen, 1);
      if (inst_ram_wen) begin
        gt = 0; ga = inst_ram_waddr; gd = inst_ram_wdata;
      end else if (data_ram_wen_initial) begin
        gt = 1; ga = data_ram_waddr_initial; gd = data_ram_wdata_initial;
      end else begin
        gt = 2; ga = {27'b0, regfile_waddr_initial}; gd = regfile_wdata_initial;
      end
      check_eq("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("write cyc=%0d tgt=%0d addr=0x%08h data=0x%08h", cyc, gt, ga, gd);
        check_eq("wr_tgt", gt, e.tgt);
        check_eq("wr_addr", ga, e.addr);
        check_eq("wr_data", gd, e.data);
        check_eq("wr_latency", cyc, e.cyc);
      end
    end
  end

  task automatic send_word(input logic [31:0] w, output int acc);
    bit got;
    got = 0;
    acc = -1;
    ld_valid = 1'b1;
    ld_data  = w;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ld_ready) begin
        @(posedge clk);
        acc = cyc;
        got = 1;
      end
    end
    #1 ld_valid = 1'b0;
    check_eq("accept", got, 1);
  endtask

  task automatic send_data(input int tgt, input logic [31:0] exp_addr, input logic [31:0] d);
    int   acc;
    exp_t e;
    send_word(d, acc);
    if (acc >= 0) begin
      e.tgt = tgt; e.addr = exp_addr; e.data = d; e.cyc = acc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic send_packet(input logic [1:0] tgt, input logic [31:0] addr, input int n,
                             input logic [31:0] seed, input logic [31:0] step,
                             input int gap, input bit bad_csum);
    logic [31:0] cmd;
    logic [31:0] sum;
    logic [31:0] d;
    logic [31:0] ea;
    int          acc;
    cmd = {tgt, 14'b0, 16'(n)};
    sum = cmd + addr;
    send_word(cmd, acc);
    send_word(addr, acc);
    for (int i = 0; i < n; i++) begin
      d   = seed + step * 32'(i);
      ea  = (tgt == 2'b10) ? ((addr + 32'(i)) & 32'h1F) : (addr + 32'(4 * i));
      sum = sum + d;
      send_data(int'(tgt), ea, d);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
`ifdef NX_LOADER_CHECKSUM_EN
    if (n != 0) send_word(bad_csum ? ~sum : sum, acc);
`else
    if (bad_csum) $display("note: checksum word not used in this build");
`endif
  endtask

  task automatic drain_and_reset(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, "_sb_drained"}, sb.size(), 0);
    sb.delete();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  initial begin : stim
    int acc;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_status", {core_rst_n, ld_busy, ld_done, ld_err, ld_ready}, 5'b00001);
    check_eq("rst_wen", {inst_ram_wen, data_ram_wen_initial, regfile_wen_initial}, 3'b000);
    check_eq("rst_addr", inst_ram_waddr | {27'b0, regfile_waddr_initial}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: instruction RAM, three back-to-back words
    send_packet(2'b00, 32'h0000_0100, 3, 32'hA000_000A, 32'h0101_0101, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t1_idle", {ld_busy, ld_err, ld_ready}, 3'b001);
    check_eq("t1_sb_empty", sb.size(), 0);

    // 2: regfile x30/x31, then out-of-range start
    send_packet(2'b10, 32'h0000_001E, 2, 32'h11, 32'h11, 0, 1'b0);
    send_word(32'h8000_0002, acc);
    send_word(32'h0000_001F, acc);
    check_eq("t2_err", {ld_err, ld_ready, core_rst_n}, 3'b100);
    drain_and_reset("t2");

    // 3: misaligned data RAM start
    send_word(32'h4000_0001, acc);
    send_word(32'h0000_0202, acc);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t3_err", {ld_err, ld_ready, ld_busy}, 3'b100);
    drain_and_reset("t3");

    // reserved command bits set
    send_word(32'h0001_0000, acc);
    check_eq("rsv_err", ld_err, 1);
    drain_and_reset("rsv");

    // 4: empty packet, then GO
    send_word(32'h4000_0000, acc);
    send_word(32'h0000_0000, acc);
    check_eq("t4_idle", {ld_busy, ld_ready, core_rst_n}, 3'b010);
    send_word(32'hC000_0000, acc);
    check_eq("t4_go", {core_rst_n, ld_done, ld_busy}, 3'b110);
    repeat (4) @(posedge clk);
    #1;
    check_eq("t4_run", {core_rst_n, ld_done, ld_ready, ld_err}, 4'b1100);
    drain_and_reset("t4");

    // 5: gapped payload, then a stall longer than the timeout
    send_packet(2'b01, 32'h0000_2000, 3, 32'h5555_0000, 32'h0000_1111, 3, 1'b0);
    check_eq("t5_noerr", ld_err, 0);
    send_word(32'h4000_0003, acc);
    send_word(32'h0000_3000, acc);
    send_data(1, 32'h0000_3000, 32'hDEAD_BEEF);
    repeat (8) @(posedge clk);
    #1;
    check_eq("t5_stall8", {ld_err, ld_busy}, 2'b01);
    @(posedge clk);
    #1;
    check_eq("t5_stall9", {ld_err, ld_ready, core_rst_n}, 3'b100);
    drain_and_reset("t5");

    // 6: reset mid-DATA, then a clean packet
    send_word(32'h0000_0004, acc);
    send_word(32'h0000_0040, acc);
    send_data(0, 32'h0000_0040, 32'h1234_5678);
    send_data(0, 32'h0000_0044, 32'h9ABC_DEF0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_status", {core_rst_n, ld_busy, ld_done, ld_err}, 4'b0000);
    check_eq("t6_rst_outs", {inst_ram_wen, inst_ram_waddr, inst_ram_wdata}, 0);
    check_eq("t6_sb_empty", sb.size(), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_packet(2'b00, 32'hFFFF_FFF8, 4, 32'h0BAD_F00D, 32'h0000_0003, 1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t6_reload", {ld_busy, ld_err, ld_ready}, 3'b001);

`ifdef NX_LOADER_CHECKSUM_EN
    send_packet(2'b01, 32'h0000_0800, 2, 32'h0000_0007, 32'h0000_0009, 0, 1'b1);
    #1;
    check_eq("cs_bad", {ld_err, ld_ready}, 2'b10);
    drain_and_reset("cs");
    send_packet(2'b01, 32'h0000_0800, 2, 32'h0000_0007, 32'h0000_0009, 0, 1'b0);
    #1;
    check_eq("cs_good", {ld_err, ld_busy, ld_ready}, 3'b001);
`endif

    repeat (3) @(posedge clk);
    #1;
    check_eq("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
